// File: rtl/dam_pkg.sv
// rtl/dam_pkg.sv - shared types and constants for the DiffAddMul host driver
package dam_pkg;

  localparam int DAM_TAG_W = 4;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } dam_op_t;

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] k;
    dam_op_t    op;
  } dam_ops_t;

  // Driven whenever the core samples but no real job may be issued
  localparam dam_ops_t DAM_BUBBLE = '{i: 8'h00, j: 8'h00, k: 8'h00, op: OP_ADD};

  typedef struct packed {
    logic [7:0]           i;
    logic [7:0]           j;
    logic [7:0]           k;
    dam_op_t              op;
    logic [DAM_TAG_W-1:0] tag;
  } dam_job_t;

  typedef struct packed {
    logic [7:0]           data;
    logic [DAM_TAG_W-1:0] tag;
  } dam_res_t;

endpackage

// File: rtl/dam_host_if.sv
// rtl/dam_host_if.sv - job, core and result signal bundle of the host driver
interface dam_host_if #(
  parameter int TAG_W = 4
) ();

  logic             job_valid;
  logic             job_ready;
  logic [7:0]       job_i;
  logic [7:0]       job_j;
  logic [7:0]       job_k;
  logic             job_op;
  logic [TAG_W-1:0] job_tag;

  logic [7:0]       i;
  logic [7:0]       j;
  logic [7:0]       k;
  logic             operation;
  logic             in_valid;
  logic [7:0]       vo;
  logic             out_valid;

  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [TAG_W-1:0] res_tag;

  modport master (
    input  job_valid, job_i, job_j, job_k, job_op, job_tag,
    input  in_valid, vo, out_valid, res_ready,
    output job_ready, i, j, k, operation,
    output res_valid, res_data, res_tag
  );

  modport slave (
    output job_valid, job_i, job_j, job_k, job_op, job_tag,
    output in_valid, vo, out_valid, res_ready,
    input  job_ready, i, j, k, operation,
    input  res_valid, res_data, res_tag
  );

endinterface

// File: rtl/dam_fifo.sv
// rtl/dam_fifo.sv - synchronous FIFO, pop-before-push when full, no bypass when empty
module dam_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dam_host.sv
// rtl/dam_host.sv - buffers jobs, feeds the DiffAddMul core and returns tagged results
module dam_host
  import dam_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dam_host_if.master             bus,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   err
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int JOB_W = $bits(dam_ops_t) + TAG_W;

  logic [JOB_W-1:0] job_rdata;
  logic             job_full;
  logic             job_empty;
  logic             job_pop;
  dam_ops_t         head_ops;
  logic [TAG_W-1:0] head_tag;

  logic [TAG_W:0]   tag_rdata;
  logic             tag_full;
  logic             tag_empty;
  logic [CW-1:0]    tag_count;
  logic             tq_bubble;
  logic [TAG_W-1:0] tq_tag;

  logic [8+TAG_W-1:0] res_rdata;
  logic               res_empty;
  logic [CW-1:0]      res_count;
  logic               res_push;

  logic [CW-1:0] real_out;
  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          real_issue;
  logic          ret_ok;
  logic          tag_push_ok;
  logic          real_inc;
  logic          real_dec;
  dam_ops_t      drive;

  assign bus.job_ready = !job_full;

  dam_fifo #(.WIDTH(JOB_W), .DEPTH(DEPTH)) u_job_q (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.job_valid && !job_full),
    .pop   (job_pop),
    .wdata ({bus.job_i, bus.job_j, bus.job_k, bus.job_op, bus.job_tag}),
    .rdata (job_rdata),
    .full  (job_full),
    .empty (job_empty),
    .count ()
  );

  assign {head_ops, head_tag} = job_rdata;

  // Real jobs between issue and downstream pop never exceed DEPTH, so the result FIFO cannot overflow
  assign credit_used = {1'b0, real_out} + {1'b0, res_count};
  assign credit_ok   = credit_used < (CW + 1)'(DEPTH);
  assign real_issue  = !job_empty && credit_ok;
  assign drive       = real_issue ? head_ops : DAM_BUBBLE;

  assign bus.i         = drive.i;
  assign bus.j         = drive.j;
  assign bus.k         = drive.k;
  assign bus.operation = drive.op;

  // A full tag queue can still accept when a return frees a slot on the same edge
  assign ret_ok      = bus.out_valid && !tag_empty;
  assign tag_push_ok = bus.in_valid && (!tag_full || ret_ok);
  assign job_pop     = tag_push_ok && real_issue;

  dam_fifo #(.WIDTH(TAG_W + 1), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push_ok),
    .pop   (ret_ok),
    .wdata ({!real_issue, head_tag}),
    .rdata (tag_rdata),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign {tq_bubble, tq_tag} = tag_rdata;
  assign res_push            = ret_ok && !tq_bubble;

  dam_fifo #(.WIDTH(8 + TAG_W), .DEPTH(DEPTH)) u_res_q (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .pop   (bus.res_valid && bus.res_ready),
    .wdata ({bus.vo, tq_tag}),
    .rdata (res_rdata),
    .full  (),
    .empty (res_empty),
    .count (res_count)
  );

  assign bus.res_valid              = !res_empty;
  assign {bus.res_data, bus.res_tag} = res_rdata;
  assign outstanding                = tag_count;

  assign real_inc = job_pop;
  assign real_dec = res_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      real_out <= '0;
      err      <= 1'b0;
    end else begin
      case ({real_inc, real_dec})
        2'b10:   real_out <= real_out + 1'b1;
        2'b01:   real_out <= real_out - 1'b1;
        default: real_out <= real_out;
      endcase
      if ((bus.in_valid && !tag_push_ok) || (bus.out_valid && tag_empty)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dam_host.sv
// tb/tb_dam_host.sv - randomized and directed bench for dam_host with a DiffAddMul core model
module tb_dam_host;
  import dam_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = DAM_TAG_W;
  localparam int LAT   = 2;

  typedef struct {
    int         due;
    logic [7:0] val;
    logic       is_real;
  } core_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   err;

  dam_host_if #(.TAG_W(TAG_W)) bus ();

  dam_host #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .outstanding (outstanding),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  dam_job_t src_q[$];
  dam_job_t pend_q[$];
  dam_res_t exp_q[$];
  dam_res_t res_log[$];
  core_t    core_q[$];

  int   cyc       = 0;
  int   avail     = 0;
  int   real_seen = 0;
  int   iv_mode   = 0;
  int   rr_pct    = 100;
  logic force_ov  = 1'b0;
  logic err_exp   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] core_fn(input dam_job_t jb);
    logic [7:0] d;
    d = jb.i - jb.j;
    if (jb.op == OP_ADD) return d + jb.k;
    return 8'(d * jb.k);
  endfunction

  function automatic dam_job_t mk_job(input int a, input int b, input int c, input int op, input int tag);
    dam_job_t jb;
    jb.i   = 8'(a);
    jb.j   = 8'(b);
    jb.k   = 8'(c);
    jb.op  = dam_op_t'(op[0]);
    jb.tag = TAG_W'(tag);
    return jb;
  endfunction

  task automatic drive_idle();
    bus.job_valid = 1'b0;
    bus.job_i     = 8'h0;
    bus.job_j     = 8'h0;
    bus.job_k     = 8'h0;
    bus.job_op    = 1'b0;
    bus.job_tag   = '0;
    bus.in_valid  = 1'b0;
    bus.vo        = 8'h0;
    bus.out_valid = 1'b0;
    bus.res_ready = 1'b0;
  endtask

  task automatic clear_model();
    src_q.delete();
    pend_q.delete();
    exp_q.delete();
    res_log.delete();
    core_q.delete();
    avail   = 0;
    err_exp = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_job_ready"}, bus.job_ready, 1);
    check({pfx, "_res_valid"}, bus.res_valid, 0);
    check({pfx, "_res_data"}, bus.res_data, 0);
    check({pfx, "_res_tag"}, bus.res_tag, 0);
    check({pfx, "_ops"}, {bus.i, bus.j, bus.k, bus.operation}, 25'h1);
    check({pfx, "_outstanding"}, outstanding, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  // One clock: drive at posedge+1, observe and score at negedge, then advance
  task automatic cycle();
    logic     ret_real;
    logic     core_ov;
    logic     exp_real;
    dam_job_t cap;
    core_t    ce;
    dam_res_t r;
    ret_real = 1'b0;
    core_ov  = 1'b0;
    if (src_q.size() > 0) begin
      bus.job_valid = 1'b1;
      bus.job_i     = src_q[0].i;
      bus.job_j     = src_q[0].j;
      bus.job_k     = src_q[0].k;
      bus.job_op    = src_q[0].op;
      bus.job_tag   = src_q[0].tag;
    end else begin
      bus.job_valid = 1'b0;
    end
    case (iv_mode)
      0:       bus.in_valid = 1'b0;
      1:       bus.in_valid = 1'b1;
      2:       bus.in_valid = 1'($urandom_range(0, 1));
      default: bus.in_valid = cyc[0];
    endcase
    if (core_q.size() > 0 && core_q[0].due == cyc + 1) begin
      bus.out_valid = 1'b1;
      bus.vo        = core_q[0].val;
      ret_real      = core_q[0].is_real;
      core_ov       = 1'b1;
      void'(core_q.pop_front());
    end else begin
      bus.out_valid = force_ov;
      bus.vo        = 8'($urandom);
    end
    bus.res_ready = ($urandom_range(0, 99) < rr_pct);

    @(negedge clk);
    check("job_ready", bus.job_ready, pend_q.size() < DEPTH);
    check("outstanding", outstanding, core_q.size() + int'(core_ov));
    check("err", err, err_exp);
    check("res_valid", bus.res_valid, avail > 0);

    if (bus.in_valid) begin
      cap.i    = bus.i;
      cap.j    = bus.j;
      cap.k    = bus.k;
      cap.op   = dam_op_t'(bus.operation);
      cap.tag  = '0;
      exp_real = pend_q.size() > 0 && exp_q.size() < DEPTH;
      if ({bus.i, bus.j, bus.k, bus.operation} != DAM_BUBBLE) real_seen++;
      if (exp_real) begin
        check("issue_ops", {bus.i, bus.j, bus.k, bus.operation},
              {pend_q[0].i, pend_q[0].j, pend_q[0].k, pend_q[0].op});
        r.data = core_fn(pend_q[0]);
        r.tag  = pend_q[0].tag;
        exp_q.push_back(r);
        void'(pend_q.pop_front());
      end else begin
        check("bubble_ops", {bus.i, bus.j, bus.k, bus.operation}, DAM_BUBBLE);
      end
      ce.due     = cyc + 1 + LAT;
      ce.val     = core_fn(cap);
      ce.is_real = exp_real;
      core_q.push_back(ce);
    end

    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() > 0) begin
        check("res_data", bus.res_data, exp_q[0].data);
        check("res_tag", bus.res_tag, exp_q[0].tag);
        r.data = bus.res_data;
        r.tag  = bus.res_tag;
        res_log.push_back(r);
        void'(exp_q.pop_front());
        avail--;
      end else begin
        check("spurious_res", bus.res_valid, 0);
      end
    end

    if (bus.job_valid && bus.job_ready) begin
      pend_q.push_back(src_q[0]);
      void'(src_q.pop_front());
    end

    @(posedge clk);
    cyc++;
    if (ret_real) avail++;
    #1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic run_until_log(input string name, input int n, input int budget);
    int b;
    b = budget;
    while (res_log.size() < n && b > 0) begin
      cycle();
      b--;
    end
    check(name, res_log.size(), n);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    drive_idle();
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int exp_mix_d [4] = '{11, 15, 0, 30};

  initial begin
    rst = 1'b1;
    drive_idle();
    #2;
    check_reset_vals("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single add
    src_q.push_back(mk_job(9, 3, 5, 1, 3));
    iv_mode = 1;
    rr_pct  = 100;
    run_until_log("single_cnt", 1, 40);
    if (res_log.size() > 0) begin
      check("single_data", res_log[0].data, 11);
      check("single_tag", res_log[0].tag, 3);
    end
    check("single_err", err, 0);

    // Mixed ordering
    res_log.delete();
    src_q.push_back(mk_job(9, 3, 5, 1, 1));
    src_q.push_back(mk_job(7, 4, 5, 0, 2));
    src_q.push_back(mk_job(2, 2, 0, 1, 3));
    src_q.push_back(mk_job(20, 10, 3, 0, 4));
    run_until_log("mix_cnt", 4, 60);
    for (int n = 0; n < 4 && n < res_log.size(); n++) begin
      check($sformatf("mix_data%0d", n), res_log[n].data, exp_mix_d[n]);
      check($sformatf("mix_tag%0d", n), res_log[n].tag, n + 1);
    end

    // Backpressure: only DEPTH real issues, then bubbles until downstream drains
    run(4);
    res_log.delete();
    real_seen = 0;
    rr_pct    = 0;
    for (int n = 0; n < 8; n++) src_q.push_back(mk_job(30 + n, 5, n + 1, n % 2, n + 5));
    run(30);
    check("bp_real_issues", real_seen, DEPTH);
    check("bp_job_ready", bus.job_ready, 0);
    check("bp_res_valid", bus.res_valid, 1);
    rr_pct = 100;
    run_until_log("bp_cnt", 8, 100);

    // Bubble discard
    res_log.delete();
    iv_mode = 3;
    run(20);
    check("bub_no_res", res_log.size(), 0);
    iv_mode = 0;
    run(4);
    check("bub_outstanding", outstanding, 0);

    // Protocol error: return with nothing issued
    force_ov = 1'b1;
    cycle();
    force_ov = 1'b0;
    check("perr_err", err, 1);
    check("perr_res_valid", bus.res_valid, 0);
    err_exp = 1'b1;
    run(3);
    sync_reset();
    check("perr_cleared", err, 0);

    // Reset mid-operation: 3 queued, 2 outstanding
    rr_pct  = 0;
    iv_mode = 0;
    for (int n = 0; n < 5; n++) src_q.push_back(mk_job(40 + n, 1, 2, 1, n));
    run(6);
    iv_mode = 1;
    run(2);
    check("mid_outstanding", outstanding, 2);
    check("mid_job_ready", bus.job_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    drive_idle();
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    iv_mode = 1;
    rr_pct  = 100;
    src_q.push_back(mk_job(10, 4, 2, 0, 7));
    run_until_log("post_rst_cnt", 1, 40);
    if (res_log.size() > 0) begin
      check("post_rst_data", res_log[0].data, 12);
      check("post_rst_tag", res_log[0].tag, 7);
    end

    // Randomized traffic with varying backpressure
    iv_mode = 2;
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       rr_pct = 100;
        1:       rr_pct = 30;
        2:       rr_pct = 0;
        default: rr_pct = 70;
      endcase
      for (int c = 0; c < 100; c++) begin
        if (src_q.size() < 2 && $urandom_range(0, 2) != 0)
          src_q.push_back(mk_job($urandom_range(0, 255), $urandom_range(0, 255),
                                 $urandom_range(0, 255), $urandom_range(0, 1),
                                 $urandom_range(0, 15)));
        cycle();
      end
    end
    rr_pct = 100;
    for (int c = 0; c < 300 && (src_q.size() + pend_q.size() + exp_q.size()) > 0; c++) cycle();
    check("rand_drain", src_q.size() + pend_q.size() + exp_q.size(), 0);
    iv_mode = 0;
    run(4);
    check("rand_idle_outstanding", outstanding, 0);
    check("rand_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
